mux_8x1_rr: RTL and testbench
=============================

MUX_8X1_RR -- requirements
Module: mux_8x1_rr

Interface
REQ-001 SHALL provide parameter DATA_W, default 8, width of each lane's data word.
REQ-002 SHALL provide port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL provide port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL provide port in_valid  input  8  per-lane request; bit i belongs to lane i.
REQ-005 SHALL provide port in_data  input  8*DATA_W  lane i word at bits [i*DATA_W +: DATA_W].
REQ-006 SHALL provide port in_ready  output  8  one-hot (or zero) accept strobe per lane.
REQ-007 SHALL provide port out_valid  output  1  output register holds a word.
REQ-008 SHALL provide port out_data  output  DATA_W  forwarded word.
REQ-009 SHALL provide port out_sel  output  3  source lane index of out_data.
REQ-010 SHALL provide port out_ready  input  1  downstream accept.

Function
REQ-011 SHALL implement a one-entry output register with two states: EMPTY (out_valid=0), FULL (out_valid=1).
REQ-012 SHALL compute load_en = EMPTY or out_ready.
REQ-013 SHALL grant the first lane with in_valid=1 searching upward from pointer ptr, wrapping 7->0.
REQ-014 SHALL drive in_ready = onehot(grant) when load_en=1 and any in_valid=1, else 8'b0; at most one bit high.
REQ-015 SHALL transfer lane g when in_valid[g] and in_ready[g] are both 1 on a clock edge.
REQ-016 SHALL, on a transfer, load out_data=lane g word, out_sel=g, set FULL; latency one cycle from transfer to out_valid.
REQ-017 SHALL, when FULL and out_ready=1 with no transfer, go EMPTY; out_data/out_sel SHALL keep the last values.
REQ-018 SHALL, when FULL, out_ready=1 and a transfer occur in the same cycle, reload and stay FULL (sustained 1 word/cycle).
REQ-019 SHALL hold out_valid, out_data, out_sel stable while FULL and out_ready=0.
REQ-020 SHALL update ptr to (g+1) mod 8 after each transfer; ptr SHALL be unchanged otherwise.
REQ-021 SHALL guarantee every continuously-asserted lane is served within 8 transfers.
REQ-022 SHALL tolerate in_valid deassertion without a transfer; grant recomputed every cycle.
REQ-023 SHALL not require out_ready to depend on out_valid; out_ready=1 while EMPTY has no effect.

Reset
REQ-024 SHALL, on rst_n low, asynchronously force EMPTY, out_valid=0, out_data=0, out_sel=0, ptr=0.
REQ-025 SHALL drive in_ready=8'b0 while rst_n is low.
REQ-026 SHALL discard any held word when reset asserts mid-operation; no transfer on the release edge's cycle occurs before the first rising edge with rst_n high.

Structure
REQ-027 SHALL place N_LANES=8, SEL_W=3 and the DATA_W default in shared package mux_pkg.
REQ-028 SHALL implement grant logic in sub-module rr_arbiter_8 (inputs req[7:0], ptr[2:0]; outputs grant[7:0], grant_idx[2:0], any).
REQ-029 SHALL keep out_data, out_sel, out_valid and ptr as registers in mux_8x1_rr; in_ready combinational.

Verification
REQ-030 SHALL test reset: rst_n low with all in_valid=1 -> in_ready=0, out_valid=0, out_sel=0; first grant after release is lane 0.
REQ-031 SHALL test round-robin: all 8 lanes valid, lane i data=8'hA0+i, out_ready=1 -> out_sel sequence 0,1,...,7,0 with matching data, one per cycle.
REQ-032 SHALL test backpressure: lane 3 data 8'h5C accepted, out_ready=0 for 4 cycles -> out_valid=1, out_data=8'h5C, out_sel=3 stable, in_ready=0 throughout.
REQ-033 SHALL test wrap/skip: ptr=6 after lane 5 served, only lanes 2 and 6 valid -> lane 6 granted, then lane 2.
REQ-034 SHALL test mid-operation reset: FULL with out_sel=4, rst_n pulsed low -> out_valid=0 immediately, ptr=0, next grant from lane 0.
REQ-035 SHALL test drain: single transfer from lane 7 then no in_valid, out_ready=1 -> out_valid high exactly one cycle, then EMPTY.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared constants and the output-register state type for the 8:1
// round-robin multiplexer.
package mux_pkg;

  localparam int N_LANES    = 8;
  localparam int SEL_W      = 3;
  localparam int DATA_W_DEF = 8;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_e;

endpackage

// File: rtl/rr_arbiter_8.sv
// Eight-way round-robin arbiter: grants the first requester at or above
// ptr, wrapping from lane 7 to lane 0.
module rr_arbiter_8
  import mux_pkg::*;
(
  input  logic [N_LANES-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic [N_LANES-1:0] grant,
  output logic [SEL_W-1:0]   grant_idx,
  output logic               any
);

  logic [SEL_W-1:0] idx;

  // NOTE: every output is defaulted before the search loop so no path
  // leaves a variable unassigned, which would otherwise infer a latch.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    idx       = '0;
    for (int i = 0; i < N_LANES; i++) begin
      idx = ptr + SEL_W'(i);
      if (!any && req[idx]) begin
        any        = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/mux_8x1_rr.sv
// 8:1 round-robin multiplexer feeding a one-entry output register with
// valid/ready handshakes on both sides.
module mux_8x1_rr
  import mux_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_LANES-1:0]        in_valid,
  input  logic [N_LANES*DATA_W-1:0] in_data,
  output logic [N_LANES-1:0]        in_ready,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         out_data,
  output logic [SEL_W-1:0]          out_sel,
  input  logic                      out_ready
);

  out_state_e         state_q, state_d;
  logic [SEL_W-1:0]   ptr_q;
  logic [N_LANES-1:0] grant;
  logic [SEL_W-1:0]   grant_idx;
  logic               any_req;
  logic               load_en;
  logic               xfer;

  rr_arbiter_8 u_arb (
    .req       (in_valid),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (any_req)
  );

  // Gating with rst_n keeps lanes from seeing an accept while in reset.
  assign load_en   = (state_q == EMPTY) || out_ready;
  assign xfer      = load_en && any_req && rst_n;
  assign in_ready  = xfer ? grant : '0;
  assign out_valid = (state_q == FULL);

  always_comb begin
    state_d = state_q;
    if (xfer)
      state_d = FULL;
    else if (out_ready)
      state_d = EMPTY;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= EMPTY;
      ptr_q    <= '0;
      out_data <= '0;
      out_sel  <= '0;
    end else begin
      state_q <= state_d;
      if (xfer) begin
        out_data <= in_data[int'(grant_idx)*DATA_W +: DATA_W];
        out_sel  <= grant_idx;
        ptr_q    <= grant_idx + SEL_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mux_8x1_rr.sv
// Directed self-checking bench for mux_8x1_rr: a vector table for the
// round-robin sweep plus hand sequences for the multi-cycle corners.
module tb_mux_8x1_rr;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  in_valid;
  logic [63:0] in_data;
  logic [7:0]  in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [2:0]  out_sel;
  logic        out_ready;
  logic [7:0]  lane_w [8];

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0] valid;
    logic       ready;
    logic [7:0] exp_in_ready;
    logic       exp_out_valid;
    logic [7:0] exp_out_data;
    logic [2:0] exp_out_sel;
  } vec_t;

  vec_t vecs [10];

  always #5 clk = ~clk;

  always_comb
    for (int i = 0; i < 8; i++) in_data[i*8 +: 8] = lane_w[i];

  mux_8x1_rr #(.DATA_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Inputs change just after a rising edge; checks follow at the falling edge.
  task automatic cyc(input logic [7:0] v, input logic r);
    @(posedge clk);
    #1;
    in_valid  = v;
    out_ready = r;
    @(negedge clk);
  endtask

  task automatic chk_out(input string name, input logic [7:0] irdy, input logic ov,
                         input logic [7:0] od, input logic [2:0] os);
    chk({name, ".in_ready"}, 32'(in_ready), 32'(irdy));
    chk({name, ".out_valid"}, 32'(out_valid), 32'(ov));
    chk({name, ".out_data"}, 32'(out_data), 32'(od));
    chk({name, ".out_sel"}, 32'(out_sel), 32'(os));
  endtask

  task automatic reset_dut();
    in_valid  = '0;
    out_ready = 1'b0;
    rst_n     = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) lane_w[i] = 8'hA0 + 8'(i);

    // Sweep: all lanes requesting, downstream always ready.
    for (int i = 0; i < 10; i++) begin
      vecs[i].valid         = 8'hFF;
      vecs[i].ready         = 1'b1;
      vecs[i].exp_in_ready  = 8'h01 << (i % 8);
      vecs[i].exp_out_valid = (i > 0);
      vecs[i].exp_out_data  = (i > 0) ? 8'hA0 + 8'((i - 1) % 8) : 8'h00;
      vecs[i].exp_out_sel   = (i > 0) ? 3'((i - 1) % 8) : 3'd0;
    end

    // Reset with every lane requesting.
    rst_n     = 1'b0;
    in_valid  = 8'hFF;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_out("reset", 8'h00, 1'b0, 8'h00, 3'd0);
    in_valid = 8'h00;
    rst_n    = 1'b1;

    for (int i = 0; i < 10; i++) begin
      cyc(vecs[i].valid, vecs[i].ready);
      chk_out($sformatf("rr[%0d]", i), vecs[i].exp_in_ready, vecs[i].exp_out_valid,
              vecs[i].exp_out_data, vecs[i].exp_out_sel);
    end

    // Backpressure: lane 3 word held while downstream stalls.
    reset_dut();
    lane_w[3] = 8'h5C;
    cyc(8'h08, 1'b0);
    chk("bp.accept", 32'(in_ready), 32'h08);
    for (int i = 0; i < 4; i++) begin
      cyc(8'h08, 1'b0);
      chk_out($sformatf("bp.hold[%0d]", i), 8'h00, 1'b1, 8'h5C, 3'd3);
    end
    cyc(8'h00, 1'b1);
    chk_out("bp.release", 8'h00, 1'b1, 8'h5C, 3'd3);
    cyc(8'h00, 1'b1);
    chk_out("bp.empty", 8'h00, 1'b0, 8'h5C, 3'd3);
    lane_w[3] = 8'hA3;

    // Wrap/skip: after lane 5, only lanes 2 and 6 request.
    reset_dut();
    cyc(8'h20, 1'b1);
    chk("wrap.lane5", 32'(in_ready), 32'h20);
    cyc(8'h44, 1'b1);
    chk_out("wrap.g6", 8'h40, 1'b1, 8'hA5, 3'd5);
    cyc(8'h44, 1'b1);
    chk_out("wrap.g2", 8'h04, 1'b1, 8'hA6, 3'd6);
    cyc(8'h00, 1'b1);
    chk_out("wrap.out2", 8'h00, 1'b1, 8'hA2, 3'd2);

    // Mid-operation reset while holding a lane-4 word.
    reset_dut();
    cyc(8'h10, 1'b0);
    chk("mid.accept", 32'(in_ready), 32'h10);
    cyc(8'hFF, 1'b0);
    chk_out("mid.full", 8'h00, 1'b1, 8'hA4, 3'd4);
    #2 rst_n = 1'b0;
    #1;
    chk_out("mid.in_reset", 8'h00, 1'b0, 8'h00, 3'd0);
    in_valid = 8'h00;
    #1 rst_n = 1'b1;
    cyc(8'hFF, 1'b1);
    chk_out("mid.regrant", 8'h01, 1'b0, 8'h00, 3'd0);

    // Drain: one lane-7 word, then idle.
    reset_dut();
    cyc(8'h80, 1'b1);
    chk("drain.accept", 32'(in_ready), 32'h80);
    cyc(8'h00, 1'b1);
    chk_out("drain.full", 8'h00, 1'b1, 8'hA7, 3'd7);
    cyc(8'h00, 1'b1);
    chk_out("drain.empty", 8'h00, 1'b0, 8'hA7, 3'd7);
    cyc(8'h00, 1'b1);
    chk("drain.stay_empty", 32'(out_valid), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
